// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: command encoding, FSM state
// encoding and the helper deriving the subtract controls from a command.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_XOR  = 3'b010;
  localparam logic [2:0] ALU_SLT  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_NAND = 3'b101;
  localparam logic [2:0] ALU_NOR  = 3'b110;
  localparam logic [2:0] ALU_OR   = 3'b111;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_FIX  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  typedef struct packed {
    logic invb;
    logic cin0;
  } sub_cfg_t;

  // SLT is a subtract followed by a sign fix-up, so it shares SUB's controls.
  function automatic sub_cfg_t sel_sub_cfg(input logic [2:0] sel);
    sub_cfg_t cfg;
    cfg.invb = (sel == ALU_SUB) || (sel == ALU_SLT);
    cfg.cin0 = cfg.invb;
    return cfg;
  endfunction

  function automatic logic sel_is_arith(input logic [2:0] sel);
    return (sel == ALU_ADD) || (sel == ALU_SUB) || (sel == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_serial_seq_if.sv
// Operand/command request channel and result response channel of the
// bit-serial ALU. master = initiator of operations, slave = the ALU.
interface alu_serial_seq_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carryout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, sel, out_ready,
    input  in_ready, out_valid, result, carryout, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, sel, out_ready,
    output in_ready, out_valid, result, carryout, overflow, zero
  );
endinterface

// File: rtl/alu_bit_op.sv
// Combinational one-bit ALU slice: full adder with optional B inversion plus
// the bitwise operations, selected by the 3-bit command.
import alu_pkg::*;

module alu_bit_op (
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       invtb,
  input  logic [2:0] sel,
  output logic       result,
  output logic       cout
);

  logic bb;
  logic sum;
  logic nand_v;
  logic nor_v;

  assign bb     = b ^ invtb;
  assign sum    = a ^ bb ^ cin;
  assign cout   = (a & bb) | (cin & (a ^ bb));
  assign nand_v = ~(a & b);
  assign nor_v  = ~(a | b);

  always_comb begin
    result = sum;
    case (sel)
      ALU_XOR:  result = a ^ b;
      ALU_AND:  result = ~nand_v;
      ALU_NAND: result = nand_v;
      ALU_NOR:  result = nor_v;
      ALU_OR:   result = ~nor_v;
      default:  result = sum;
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: one bit per cycle through a single alu_bit_op.
// Optional SLT fix-up cycle enabled by defining ALU_SERIAL_SLT_EN.
//
// state   | meaning
// IDLE    | in_ready high, waiting for an operation
// RUN     | evaluating bit cnt_q, LSB first
// FIX     | SLT only: replace result with the signed less-than bit
// DONE    | out_valid high, result/flags held until out_ready
import alu_pkg::*;

module alu_serial_seq #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_serial_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [2:0]       sel_q, sel_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             nz_q, nz_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic     slice_res;
  logic     slice_cout;
  logic     last_bit;
  sub_cfg_t run_cfg;
  sub_cfg_t in_cfg;

  assign run_cfg  = sel_sub_cfg(sel_q);
  assign in_cfg   = sel_sub_cfg(bus.sel);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  alu_bit_op u_bit_op (
    .a      (a_q[0]),
    .b      (b_q[0]),
    .cin    (carry_q),
    .invtb  (run_cfg.invb),
    .sel    (sel_q),
    .result (slice_res),
    .cout   (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    nz_d    = nz_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sel_d   = bus.sel;
          cnt_d   = '0;
          carry_d = in_cfg.cin0;
          nz_d    = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {slice_res, res_q[WIDTH-1:1]};
        carry_d = slice_cout;
        nz_d    = nz_q | slice_res;
        if (last_bit) begin
          // carry_q here is the carry into the MSB
          cout_d  = sel_is_arith(sel_q) & slice_cout;
          ovf_d   = sel_is_arith(sel_q) & (carry_q ^ slice_cout);
          zero_d  = ~(nz_q | slice_res);
`ifdef ALU_SERIAL_SLT_EN
          state_d = (sel_q == ALU_SLT) ? ST_FIX : ST_DONE;
`else
          state_d = ST_DONE;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef ALU_SERIAL_SLT_EN
      ST_FIX: begin
        res_d    = '0;
        res_d[0] = res_q[WIDTH-1] ^ ovf_q;
        zero_d   = ~(res_q[WIDTH-1] ^ ovf_q);
        state_d  = ST_DONE;
      end
`endif
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sel_q   <= ALU_ADD;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      nz_q    <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      nz_q    <= nz_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = res_q;
  assign bus.carryout  = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Scoreboard bench for alu_serial_seq at WIDTH=8; expectations follow
// ALU_SERIAL_SLT_EN when it is defined for the build.
module tb_alu_serial_seq;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
    int           lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   cyc;
  int   accept_cyc;
  exp_t sb[$];

  alu_serial_seq_if #(.WIDTH(W)) bus ();

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks = n_checks + 1;
    if (act !== req) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: compare the scoreboard head when out_valid rises.
  initial begin : monitor
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1 && prev_v !== 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          check("result",   int'(bus.result),   int'(e.res));
          check("carryout", int'(bus.carryout), int'(e.c));
          check("overflow", int'(bus.overflow), int'(e.v));
          check("zero",     int'(bus.zero),     int'(e.z));
          check("latency",  cyc - accept_cyc,   e.lat);
        end
      end
      prev_v = bus.out_valid;
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] sel);
    int t;
    t = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) check("in_ready_timeout", 0, 1);
    bus.a = a;
    bus.b = b;
    bus.sel = sel;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    bus.in_valid = 1'b0;
    bus.a = 8'hAA;
    bus.b = 8'h55;
    bus.sel = 3'b111;
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [2:0] sel, input logic [W-1:0] res,
                    input logic c, input logic v, input logic z, input int lat);
    exp_t e;
    e.res = res; e.c = c; e.v = v; e.z = z; e.lat = lat;
    sb.push_back(e);
    issue(a, b, sel);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || bus.out_valid === 1'b1) && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) check("drain_timeout", 0, 1);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    cyc = 0;
    accept_cyc = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.sel = '0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_in_ready",  int'(bus.in_ready),  1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_result",    int'(bus.result),    0);
    check("rst_flags", int'({bus.carryout, bus.overflow, bus.zero}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    op(8'h7F, 8'h01, 3'b000, 8'h80, 1'b0, 1'b1, 1'b0, 8); drain();
    op(8'h05, 8'h05, 3'b001, 8'h00, 1'b1, 1'b0, 1'b1, 8); drain();
`ifdef ALU_SERIAL_SLT_EN
    op(8'h80, 8'h01, 3'b011, 8'h01, 1'b1, 1'b1, 1'b0, 9); drain();
    op(8'h05, 8'h03, 3'b011, 8'h00, 1'b1, 1'b0, 1'b1, 9); drain();
`else
    op(8'h80, 8'h01, 3'b011, 8'h7F, 1'b1, 1'b1, 1'b0, 8); drain();
    op(8'h05, 8'h03, 3'b011, 8'h02, 1'b1, 1'b0, 1'b0, 8); drain();
`endif
    op(8'hF0, 8'hFF, 3'b101, 8'h0F, 1'b0, 1'b0, 1'b0, 8); drain();
    op(8'h00, 8'h00, 3'b111, 8'h00, 1'b0, 1'b0, 1'b1, 8); drain();
    op(8'hA5, 8'h5A, 3'b010, 8'hFF, 1'b0, 1'b0, 1'b0, 8); drain();
    op(8'hF0, 8'h3C, 3'b100, 8'h30, 1'b0, 1'b0, 1'b0, 8); drain();
    op(8'h0F, 8'hF0, 3'b110, 8'h00, 1'b0, 1'b0, 1'b1, 8); drain();
    op(8'h03, 8'h05, 3'b001, 8'hFE, 1'b0, 1'b0, 1'b0, 8); drain();
    op(8'hFF, 8'h01, 3'b000, 8'h00, 1'b1, 1'b0, 1'b1, 8); drain();

    // Backpressure: hold DONE, offer a new op that must be ignored.
    bus.out_ready = 1'b0;
    op(8'h10, 8'h20, 3'b000, 8'h30, 1'b0, 1'b0, 1'b0, 8);
    begin : wait_done
      int t;
      t = 0;
      while (bus.out_valid !== 1'b1 && t < 40) begin
        @(negedge clk);
        t++;
      end
      if (t >= 40) check("bp_wait_timeout", 0, 1);
    end
    bus.a = 8'h01;
    bus.b = 8'h01;
    bus.sel = 3'b000;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", int'(bus.out_valid), 1);
      check("bp_result",    int'(bus.result),    8'h30);
      check("bp_in_ready",  int'(bus.in_ready),  0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready",  int'(bus.in_ready),  1);
    check("bp_release_out_valid", int'(bus.out_valid), 0);

    // Reset during RUN bit 3: no result may be presented.
    issue(8'h55, 8'h11, 3'b000);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_in_ready",  int'(bus.in_ready),  1);
    check("midrst_result",    int'(bus.result),    0);
    @(negedge clk);
    rst_n = 1'b1;
    op(8'h01, 8'h02, 3'b000, 8'h03, 1'b0, 1'b0, 1'b0, 8); drain();
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_serial_seq.md
# alu_serial_seq

Bit-serial ALU sequencer that accepts a full-width operand pair and 3-bit command over a valid/ready handshake. It evaluates the operation one bit per cycle through a single one-bit ALU slice, with carry held in a flop between cycles. It returns the full-width result with carryout, overflow and zero flags over a second valid/ready handshake. It is the area-minimal alternative to the ripple-parallel ALU and drives the slice interface from the initiator side.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand/command offer
- in_ready  output  1  block idle, may accept
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sel  input  3  command: 000 ADD, 001 SUB, 010 XOR, 011 SLT, 100 AND, 101 NAND, 110 NOR, 111 OR
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  operation result
- carryout  output  1  carry out of MSB (ADD/SUB/SLT), else 0
- overflow  output  1  signed overflow (ADD/SUB/SLT), else 0
- zero  output  1  result == 0

## Operation
- FSM states: IDLE, RUN, FIX, DONE. Reset state is IDLE.
- Reset values: in_ready 1, out_valid 0, result 0, carryout 0, overflow 0, zero 0.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture a, b, sel into shift registers and clear bit counter.
  - Carry flop loads 1 for SUB/SLT, 0 otherwise. Go to RUN.
- RUN:
  - Slice evaluates bit k from the LSBs of the A/B shift registers; invert-B is applied for SUB/SLT.
  - ADD/SUB/SLT use the sum. AND = NOT NAND. OR = NOT NOR.
  - Each edge: shift A/B right, shift the result bit into the result MSB, update the carry flop, OR-accumulate the zero flag, increment the counter.
  - On the last bit (k = WIDTH-1): overflow = carry_in_msb XOR carry_out_msb, and carryout = carry_out_msb.
  - Next state: FIX if sel = SLT, else DONE.
- FIX (SLT only), one cycle:
  - result = {WIDTH-1 zeros, sum_msb XOR overflow}.
  - zero recomputed from the new result. Go to DONE.
- DONE:
  - out_valid = 1; result and flags held stable.
  - On out_valid & out_ready: go to IDLE and clear out_valid.
- Logic ops force carryout and overflow to 0.
- in_valid is ignored outside IDLE. a/b/sel changes after acceptance are ignored.
- Reset asserted in any state: immediate return to IDLE with reset output values; the in-flight op is discarded and no partial result is presented.

## Timing
- Accept edge E0.
- out_valid rises after edge E_WIDTH (latency WIDTH cycles), or after E_(WIDTH+1) for SLT.
- Transfer at the edge where out_valid & out_ready are both high. in_ready is high the following cycle, so there is no same-cycle accept-on-retire.
- Minimum op-to-op spacing: WIDTH+2 cycles (WIDTH+3 for SLT).
- out_ready held low: state stays in DONE indefinitely, outputs unchanged.
- out_ready already high when out_valid rises: transfer on that first DONE edge.

## Configuration
- ALU_SERIAL_SLT_EN defined: SLT is supported as above, including the FIX state.
- ALU_SERIAL_SLT_EN undefined:
  - FIX state is not compiled in.
  - sel 011 executes identically to SUB: result, flags and latency are all WIDTH cycles.

## Structure
- Shared package alu_pkg holds:
  - the sel encoding localparams (ALU_ADD … ALU_OR);
  - the FSM state typedef;
  - the helper that derives invert-B and initial carry from sel.
- One sub-module, alu_bit_op: a combinational one-bit slice taking a, b, cin, invtb, sel and producing result and cout. It is instantiated once.
- Shift registers, counter (clog2(WIDTH) bits, no wrap beyond WIDTH-1), carry/zero/overflow flops and the FSM live in the top.

## Test plan
- WIDTH=8, ADD 8'h7F+8'h01 → result 8'h80, overflow 1, carryout 0, zero 0; out_valid first high 8 cycles after accept.
- SUB 8'h05−8'h05 → result 8'h00, zero 1, carryout 1, overflow 0.
- SLT a=8'h80, b=8'h01 → result 8'h01 at 9 cycles. With the macro undefined → result 8'h7F, overflow 1, at 8 cycles.
- NAND a=8'hF0, b=8'hFF → result 8'h0F, carryout 0, overflow 0. OR 8'h00|8'h00 → zero 1.
- Backpressure: hold out_ready low 5 cycles in DONE → out_valid and result stable, in_ready 0, new in_valid ignored. Raise out_ready → next cycle in_ready 1.
- Assert rst_n low during RUN bit 3 → out_valid 0 and in_ready 1 immediately. After release, ADD 8'h01+8'h02 → 8'h03 with correct flags.
